launch_arbiter: RTL and testbench

LAUNCH_ARBITER -- requirements
Module: launch_arbiter

---
 rtl/launch_pkg.sv | 24 ++
 rtl/launch_rr_pick.sv | 26 ++
 rtl/launch_arbiter.sv | 148 ++++++++++++++
 tb/tb_launch_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/launch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : launch_pkg
//  Brief    : Shared launch-RAM geometry, arbiter state encoding and helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package launch_pkg;

    localparam int LAUNCH_AW    = 8;
    localparam int LAUNCH_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } launch_state_t;

    // Write-pointer advance, wrapping at the RAM depth.
    function automatic logic [LAUNCH_AW-1:0] launch_ptr_next(input logic [LAUNCH_AW-1:0] ptr);
        return LAUNCH_AW'((int'(ptr) + 1) % LAUNCH_DEPTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/launch_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : launch_rr_pick
//  Brief    : Combinational 2-way round-robin picker (valids, last served -> index).
//  Revision : 1.0 - initial release
// ============================================================================
module launch_rr_pick (
    input  logic [1:0] i_valid,
    input  logic       i_last_served,
    output logic       o_any,
    output logic       o_idx
);

    always_comb begin
        o_any = |i_valid;
        o_idx = 1'b0;
        case (i_valid)
            2'b01:   o_idx = 1'b0;
            2'b10:   o_idx = 1'b1;
            2'b11:   o_idx = ~i_last_served;
            default: o_idx = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/launch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : launch_arbiter
//  Brief    : Two-requester frame arbiter writing bytes into the launch RAM.
//             Define LAUNCH_ARB_FRAME_CNT_EN to add the l_frame_cnt_o counter.
//  Revision : 1.0 - initial release
// ============================================================================
module launch_arbiter
    import launch_pkg::*;
#(
    parameter logic EN_W     = 1'b1,
    parameter logic EN_RESET = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req0_valid_i,
    input  logic [7:0]           req0_data_i,
    input  logic                 req0_last_i,
    output logic                 req0_ready_o,
    input  logic                 req1_valid_i,
    input  logic [7:0]           req1_data_i,
    input  logic                 req1_last_i,
    output logic                 req1_ready_o,
    input  logic [LAUNCH_AW-1:0] l_addr_counter_i,
    output logic                 l_en_w_o,
    output logic [LAUNCH_AW-1:0] l_w_addr_o,
    output logic [7:0]           l_data_o,
    output logic                 l_full_o,
    output logic                 l_busy_o
`ifdef LAUNCH_ARB_FRAME_CNT_EN
    ,
    output logic [15:0]          l_frame_cnt_o
`endif
);

    launch_state_t        r_state;
    launch_state_t        w_state_nxt;
    logic [LAUNCH_AW-1:0] r_wr_ptr;
    logic [LAUNCH_AW-1:0] r_rd_q;
    logic                 r_last_served;
    logic                 r_en_w;
    logic [LAUNCH_AW-1:0] r_w_addr;
    logic [7:0]           r_data;

    logic                 w_rst;
    logic                 w_full;
    logic                 w_ready0;
    logic                 w_ready1;
    logic                 w_xfer0;
    logic                 w_xfer1;
    logic                 w_xfer;
    logic                 w_last;
    logic [7:0]           w_data;
    logic                 w_any;
    logic                 w_pick_idx;

    assign w_rst = (rst_i == EN_RESET);

    launch_rr_pick u_rr_pick (
        .i_valid       ({req1_valid_i, req0_valid_i}),
        .i_last_served (r_last_served),
        .o_any         (w_any),
        .o_idx         (w_pick_idx)
    );

    // One slot stays empty so that wr_ptr == rd_q always means "empty".
    assign w_full   = (launch_ptr_next(r_wr_ptr) == r_rd_q);
    assign w_ready0 = (r_state == GRANT0) && !w_full;
    assign w_ready1 = (r_state == GRANT1) && !w_full;
    assign w_xfer0  = req0_valid_i && w_ready0;
    assign w_xfer1  = req1_valid_i && w_ready1;
    assign w_xfer   = w_xfer0 || w_xfer1;
    assign w_data   = w_xfer1 ? req1_data_i : req0_data_i;
    assign w_last   = w_xfer1 ? req1_last_i : req0_last_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_pick_idx ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                if (w_xfer0 && req0_last_i) begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT1: begin
                if (w_xfer1 && req1_last_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_rd_q        <= '0;
            r_last_served <= 1'b1;
            r_en_w        <= ~EN_W;
            r_w_addr      <= '0;
            r_data        <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_q  <= l_addr_counter_i;
            r_en_w  <= w_xfer ? EN_W : ~EN_W;
            if (w_xfer) begin
                r_w_addr <= r_wr_ptr;
                r_data   <= w_data;
                r_wr_ptr <= launch_ptr_next(r_wr_ptr);
            end
            if ((r_state == IDLE) && w_any) begin
                r_last_served <= w_pick_idx;
            end
        end
    end

`ifdef LAUNCH_ARB_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_frame_cnt <= '0;
        end else if (w_xfer && w_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign l_frame_cnt_o = r_frame_cnt;
`else
    logic w_last_unused;
    assign w_last_unused = w_last;
`endif

    assign req0_ready_o = w_ready0;
    assign req1_ready_o = w_ready1;
    assign l_en_w_o     = r_en_w;
    assign l_w_addr_o   = r_w_addr;
    assign l_data_o     = r_data;
    assign l_full_o     = w_full;
    assign l_busy_o     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_launch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_launch_arbiter
//  Brief    : Scoreboard bench for launch_arbiter: directed frames, stalls, wrap, reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_launch_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req0_valid_i = 1'b0;
    logic [7:0] req0_data_i  = 8'h00;
    logic       req0_last_i  = 1'b0;
    logic       req0_ready_o;
    logic       req1_valid_i = 1'b0;
    logic [7:0] req1_data_i  = 8'h00;
    logic       req1_last_i  = 1'b0;
    logic       req1_ready_o;
    logic [7:0] l_addr_counter_i = 8'h00;
    logic       l_en_w_o;
    logic [7:0] l_w_addr_o;
    logic [7:0] l_data_o;
    logic       l_full_o;
    logic       l_busy_o;
`ifdef LAUNCH_ARB_FRAME_CNT_EN
    logic [15:0] l_frame_cnt_o;
`endif

    launch_arbiter dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req0_valid_i     (req0_valid_i),
        .req0_data_i      (req0_data_i),
        .req0_last_i      (req0_last_i),
        .req0_ready_o     (req0_ready_o),
        .req1_valid_i     (req1_valid_i),
        .req1_data_i      (req1_data_i),
        .req1_last_i      (req1_last_i),
        .req1_ready_o     (req1_ready_o),
        .l_addr_counter_i (l_addr_counter_i),
        .l_en_w_o         (l_en_w_o),
        .l_w_addr_o       (l_w_addr_o),
        .l_data_o         (l_data_o),
        .l_full_o         (l_full_o),
        .l_busy_o         (l_busy_o)
`ifdef LAUNCH_ARB_FRAME_CNT_EN
        ,
        .l_frame_cnt_o    (l_frame_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int       cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t sb[$];
    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc      = 0;
    bit      mon_en   = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write strobe must match the oldest expected write.
    always @(negedge clk_i) begin : monitor
        wr_exp_t e;
        if (mon_en && (l_en_w_o !== 1'b0)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: en=%b addr=%0h data=%0h (cycle %0d), none expected",
                         l_en_w_o, l_w_addr_o, l_data_o, cyc);
            end else begin
                e = sb.pop_front();
                if ((l_en_w_o !== 1'b1) || (l_w_addr_o !== e.addr) ||
                    (l_data_o !== e.data) || (cyc != e.cyc)) begin
                    n_errors++;
                    $display("FAIL ram_write: got addr=%0h data=%0h cycle=%0d expected addr=%0h data=%0h cycle=%0d",
                             l_w_addr_o, l_data_o, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    // Offer one beat on port p; once ready is seen the write is expected next cycle.
    task automatic beat(input int p, input logic [7:0] d, input logic lst, input logic [7:0] a);
        int waitc = 0;
        if (p == 0) begin
            req0_valid_i = 1'b1; req0_data_i = d; req0_last_i = lst;
        end else begin
            req1_valid_i = 1'b1; req1_data_i = d; req1_last_i = lst;
        end
        while ((((p == 0) ? req0_ready_o : req1_ready_o) !== 1'b1) && (waitc <= 20)) begin
            @(posedge clk_i); #1;
            waitc++;
        end
        if (waitc > 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: port %0d ready=0 for %0d cycles, required 1", p, waitc);
        end else begin
            sb.push_back('{cyc + 1, a, d});
            @(posedge clk_i); #1;
        end
    endtask

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset state
        tick(); tick();
        chk("rst_en_w",   {31'd0, l_en_w_o},     32'd0);
        chk("rst_w_addr", {24'd0, l_w_addr_o},   32'd0);
        chk("rst_data",   {24'd0, l_data_o},     32'd0);
        chk("rst_ready0", {31'd0, req0_ready_o}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready_o}, 32'd0);
        chk("rst_busy",   {31'd0, l_busy_o},     32'd0);
        chk("rst_full",   {31'd0, l_full_o},     32'd0);
        rst_i  = 1'b0;
        mon_en = 1'b1;

        // Single frame from req0: A1,A2,A3 -> addr 0,1,2
        beat(0, 8'hA1, 1'b0, 8'd0);
        beat(0, 8'hA2, 1'b0, 8'd1);
        beat(0, 8'hA3, 1'b1, 8'd2);
        req0_valid_i = 1'b0; req0_last_i = 1'b0;
        chk("frameA_idle_busy", {31'd0, l_busy_o},     32'd0);
        chk("frameA_ready0",    {31'd0, req0_ready_o}, 32'd0);
        tick();
        chk("hold_en_w",   {31'd0, l_en_w_o},   32'd0);
        chk("hold_w_addr", {24'd0, l_w_addr_o}, 32'd2);
        chk("hold_data",   {24'd0, l_data_o},   32'hA3);
`ifdef LAUNCH_ARB_FRAME_CNT_EN
        chk("frame_cnt_A", {16'd0, l_frame_cnt_o}, 32'd1);
`endif

        // Fresh reset, then tie between requesters: req0 wins first
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        req1_valid_i = 1'b1; req1_data_i = 8'hC1; req1_last_i = 1'b1;
        req0_valid_i = 1'b1; req0_data_i = 8'hB1; req0_last_i = 1'b0;
        chk("tie_idle_ready1", {31'd0, req1_ready_o}, 32'd0);
        beat(0, 8'hB1, 1'b0, 8'd0);
        chk("tie_req1_blocked", {31'd0, req1_ready_o}, 32'd0);
        beat(0, 8'hB2, 1'b1, 8'd1);
        // req0 re-requests immediately: tie again, req1 must now win
        req0_valid_i = 1'b1; req0_data_i = 8'hD1; req0_last_i = 1'b1;
        chk("gap_ready1", {31'd0, req1_ready_o}, 32'd0);
        chk("gap_busy",   {31'd0, l_busy_o},     32'd0);
        tick();
        chk("rr_ready1", {31'd0, req1_ready_o}, 32'd1);
        chk("rr_ready0", {31'd0, req0_ready_o}, 32'd0);
        beat(1, 8'hC1, 1'b1, 8'd2);
        req1_valid_i = 1'b0; req1_last_i = 1'b0;
        beat(0, 8'hD1, 1'b1, 8'd3);
        req0_valid_i = 1'b0; req0_last_i = 1'b0;
`ifdef LAUNCH_ARB_FRAME_CNT_EN
        chk("frame_cnt_BCD", {16'd0, l_frame_cnt_o}, 32'd3);
`endif

        // Full: pointer 4, read position 5
        l_addr_counter_i = 8'd5;
        tick();
        chk("full_set", {31'd0, l_full_o}, 32'd1);
        req0_valid_i = 1'b1; req0_data_i = 8'hE1; req0_last_i = 1'b1;
        tick();
        chk("full_busy",   {31'd0, l_busy_o},     32'd1);
        chk("full_ready0", {31'd0, req0_ready_o}, 32'd0);
        tick();
        chk("full_hold_ready0", {31'd0, req0_ready_o}, 32'd0);
        l_addr_counter_i = 8'd6;
        chk("full_rdq_registered", {31'd0, req0_ready_o}, 32'd0);
        chk("full_still",          {31'd0, l_full_o},     32'd1);
        beat(0, 8'hE1, 1'b1, 8'd4);
        req0_valid_i = 1'b0; req0_last_i = 1'b0;

        // Fill addresses 5..254 in one frame, then wrap 255 -> 0
        l_addr_counter_i = 8'd3;
        tick();
        for (int i = 5; i <= 254; i++) begin
            beat(0, 8'(i) ^ 8'h3C, (i == 254), 8'(i));
        end
        req0_valid_i = 1'b0; req0_last_i = 1'b0;
        l_addr_counter_i = 8'd10;
        tick();
        chk("wrap_not_full", {31'd0, l_full_o}, 32'd0);
        beat(0, 8'h77, 1'b0, 8'd255);
        beat(0, 8'h78, 1'b1, 8'd0);
        req0_valid_i = 1'b0; req0_last_i = 1'b0;

        // Reset in the middle of a frame after two bytes
        beat(0, 8'hC1, 1'b0, 8'd1);
        beat(0, 8'hC2, 1'b0, 8'd2);
        req0_data_i = 8'hC3;
        rst_i = 1'b1;
        tick();
        chk("midrst_en_w",   {31'd0, l_en_w_o},     32'd0);
        chk("midrst_w_addr", {24'd0, l_w_addr_o},   32'd0);
        chk("midrst_data",   {24'd0, l_data_o},     32'd0);
        chk("midrst_ready0", {31'd0, req0_ready_o}, 32'd0);
        chk("midrst_busy",   {31'd0, l_busy_o},     32'd0);
`ifdef LAUNCH_ARB_FRAME_CNT_EN
        chk("midrst_frame_cnt", {16'd0, l_frame_cnt_o}, 32'd0);
`endif
        rst_i = 1'b0;
        req0_valid_i = 1'b0; req0_last_i = 1'b0;
        beat(1, 8'hD5, 1'b1, 8'd0);
        req1_valid_i = 1'b0; req1_last_i = 1'b0;
`ifdef LAUNCH_ARB_FRAME_CNT_EN
        chk("post_rst_frame_cnt", {16'd0, l_frame_cnt_o}, 32'd1);
`endif

        tick(); tick(); tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
